waiter_nav_sequencer: RTL and testbench
=======================================

Name: waiter_nav_sequencer

Overview:
- Top-level navigation state machine for the waiter robot.
- Generates the 4-bit `direction` state that drives the continuous motor-control pulser.
- Sequences a delivery trip: leave base, turn, seek table, dwell, back out, turn back, seek home.
- Forward travel is paused on obstacles and resumed with the remaining time preserved.

Parameters:
- FWD_CYCLES, 100_000_000: cycles spent in FORWARDS and in BACKWARDS.
- TURN_CYCLES, 75_000_000: cycles spent in TURN and in TURN_BACK.
- DWELL_CYCLES, 250_000_000: maximum cycles in IDLE_TABLE.
- CLEAR_CYCLES, 25_000_000: consecutive obstacle-free cycles required before resuming from STOP.
- SEEK_TIMEOUT, 1_500_000_000: seek watchdog limit; used only with NAV_TIMEOUT_EN.
- All parameters are at least 1 and fit in 32 bits unsigned.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  trip request, level or pulse; sampled only in IDLE_BASE.
- obstacle  in  1  forward ultrasonic below threshold.
- table_seen  in  1  table marker detected by the colour pipeline.
- home_seen  in  1  base marker detected.
- collect  in  1  customer took the item; ends the dwell early.
- direction  out  4  encoded state: IDLE_BASE=0, FORWARDS=1, TURN=2, TO_TABLE=3, IDLE_TABLE=4, BACKWARDS=5, TURN_BACK=6, RETURN_HOME=7, STOP=8.
- busy  out  1  high whenever direction != IDLE_BASE.
- fault  out  1  watchdog fault (see Optional Feature).

Behaviour:
- Registers and outputs:
  - direction, busy and fault are registered; all inputs are sampled on posedge clk.
  - Reset: direction=0, busy=0, fault=0, timer=0, clear counter=0, saved state=IDLE_BASE.
  - Reset wins over every other event, including mid-trip and while in STOP.
- Timer:
  - 32-bit down-counter, loaded with the state's parameter on entry to each timed state.
  - Decrements once per cycle.
  - Leaves the state on the cycle the timer reads 1, so direction shows that state for exactly N cycles.
- Transitions:
  - IDLE_BASE: start=1 -> FORWARDS on the next cycle.
  - FORWARDS: timer expiry -> TURN.
  - TURN: after TURN_CYCLES -> TO_TABLE.
  - TO_TABLE: table_seen=1 -> IDLE_TABLE; untimed unless NAV_TIMEOUT_EN.
  - IDLE_TABLE: collect=1 or DWELL expiry -> BACKWARDS; collect takes effect in the same cycle it is sampled.
  - BACKWARDS: after FWD_CYCLES -> TURN_BACK.
  - TURN_BACK: after TURN_CYCLES -> RETURN_HOME.
  - RETURN_HOME: home_seen=1 -> IDLE_BASE.
- Obstacle handling:
  - Monitored only in FORWARDS and TO_TABLE, the forward-moving states.
  - obstacle=1 -> STOP. The current state is saved and the timer is frozen, not reloaded.
  - In STOP, the clear counter increments while obstacle=0 and resets to 0 whenever obstacle=1.
  - When the counter reaches CLEAR_CYCLES, return to the saved state with the remaining timer value.
- Priority, same cycle:
  - rst > obstacle > marker / timer / collect.
  - Example: obstacle and FORWARDS expiry in the same cycle -> STOP; TURN is entered after the resume with timer=1, i.e. one cycle later.
- Ignored inputs:
  - Markers outside their seek state.
  - start outside IDLE_BASE.
  - collect outside IDLE_TABLE.
  - obstacle in all non-monitored states.
- No illegal-state lockup: codes 9–15 decode to IDLE_BASE on the next cycle.

Optional Feature:
- Macro: NAV_TIMEOUT_EN.
- Defined:
  - A separate 32-bit seek counter loads SEEK_TIMEOUT on entry to TO_TABLE or RETURN_HOME.
  - It counts only while in those states and is frozen in STOP.
  - If it expires before the marker is seen: fault=1 and direction=STOP.
  - The fault is latched until rst; obstacle clearing does not resume.
  - A marker seen in the expiry cycle wins, so no fault is raised.
- Undefined: fault is tied to 0 and seeks wait indefinitely; no seek counter logic is present.

Test Plan:
- Bench overrides: FWD=4, TURN=3, DWELL=5, CLEAR=2, SEEK_TIMEOUT=10.
- Full trip:
  - Stimulus: reset, start pulse, table_seen on the 2nd TO_TABLE cycle, no collect, home_seen on the 1st RETURN_HOME cycle.
  - Required direction sequence: 0, 1×4, 2×3, 3×2, 4×5, 5×4, 6×3, 7×1, 0; busy high throughout the trip.
- Obstacle pause:
  - Stimulus: obstacle=1 on the 2nd FORWARDS cycle for 3 cycles, then 0.
  - Required: direction=8 for 3+2 cycles, then 1 for the remaining 3 cycles, then 2.
- Obstacle bounce:
  - Stimulus: in STOP, obstacle pattern 0,1,0,0.
  - Required: resume only after the final two clear cycles.
- Ignored obstacle and early collect:
  - Stimulus: obstacle=1 throughout TURN and BACKWARDS; collect on the 1st IDLE_TABLE cycle.
  - Required: no STOP; IDLE_TABLE lasts 1 cycle.
- Reset mid-trip:
  - Stimulus: rst during STOP.
  - Required: direction=0, busy=0 the next cycle; a subsequent start gives a full 4-cycle FORWARDS.
- NAV_TIMEOUT_EN fault:
  - Stimulus: no table_seen.
  - Required: after 10 TO_TABLE cycles, direction=8 and fault=1; both hold through obstacle toggling until rst.

Source files
------------

// File: rtl/waiter_nav_sequencer.sv
// waiter_nav_sequencer: top-level trip sequencer for the waiter robot.
// Drives the 4-bit direction code consumed by the motor pulser, pauses
// forward travel on obstacles and resumes with the remaining time intact.
// Optional seek watchdog: define NAV_TIMEOUT_EN to enable the fault output.
module waiter_nav_sequencer #(
    parameter int unsigned FWD_CYCLES   = 100_000_000,
    parameter int unsigned TURN_CYCLES  = 75_000_000,
    parameter int unsigned DWELL_CYCLES = 250_000_000,
    parameter int unsigned CLEAR_CYCLES = 25_000_000,
    parameter int unsigned SEEK_TIMEOUT = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       obstacle,
    input  logic       table_seen,
    input  logic       home_seen,
    input  logic       collect,
    output logic [3:0] direction,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_IDLE_BASE   = 4'd0,
        S_FORWARDS    = 4'd1,
        S_TURN        = 4'd2,
        S_TO_TABLE    = 4'd3,
        S_IDLE_TABLE  = 4'd4,
        S_BACKWARDS   = 4'd5,
        S_TURN_BACK   = 4'd6,
        S_RETURN_HOME = 4'd7,
        S_STOP        = 4'd8
    } state_t;

    // Every cycle count must be non-zero for the timed states to make sense.
    if (FWD_CYCLES == 0 || TURN_CYCLES == 0 || DWELL_CYCLES == 0 ||
        CLEAR_CYCLES == 0 || SEEK_TIMEOUT == 0) begin : g_bad_params
        $error("waiter_nav_sequencer: cycle parameters must be at least 1");
    end

    state_t      state_q, state_d;
    state_t      saved_q, saved_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] clear_q, clear_d;
    logic        busy_q;

`ifdef NAV_TIMEOUT_EN
    logic [31:0] seek_q, seek_d;
    logic        fault_q, fault_d;
`endif

    // Next-state, timer, obstacle-clear and watchdog computation.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        timer_d = timer_q;
        clear_d = clear_q;
`ifdef NAV_TIMEOUT_EN
        seek_d  = seek_q;
        fault_d = fault_q;
`endif
        case (state_q)
            S_IDLE_BASE: begin
                timer_d = '0;
                if (start) begin
                    state_d = S_FORWARDS;
                    timer_d = FWD_CYCLES;
                end
            end
            S_FORWARDS: begin
                // Obstacle outranks expiry; the timer is held so the
                // unfinished distance is still driven after the resume.
                if (obstacle) begin
                    state_d = S_STOP;
                    saved_d = S_FORWARDS;
                    clear_d = '0;
                end else if (timer_q <= 32'd1) begin
                    state_d = S_TURN;
                    timer_d = TURN_CYCLES;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_TURN: begin
                if (timer_q <= 32'd1) begin
                    state_d = S_TO_TABLE;
                    timer_d = '0;
`ifdef NAV_TIMEOUT_EN
                    seek_d  = SEEK_TIMEOUT;
`endif
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_TO_TABLE: begin
                if (obstacle) begin
                    state_d = S_STOP;
                    saved_d = S_TO_TABLE;
                    clear_d = '0;
                end else if (table_seen) begin
                    state_d = S_IDLE_TABLE;
                    timer_d = DWELL_CYCLES;
                end
`ifdef NAV_TIMEOUT_EN
                else if (seek_q <= 32'd1) begin
                    state_d = S_STOP;
                    fault_d = 1'b1;
                end else begin
                    seek_d = seek_q - 32'd1;
                end
`endif
            end
            S_IDLE_TABLE: begin
                if (collect || timer_q <= 32'd1) begin
                    state_d = S_BACKWARDS;
                    timer_d = FWD_CYCLES;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_BACKWARDS: begin
                if (timer_q <= 32'd1) begin
                    state_d = S_TURN_BACK;
                    timer_d = TURN_CYCLES;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_TURN_BACK: begin
                if (timer_q <= 32'd1) begin
                    state_d = S_RETURN_HOME;
                    timer_d = '0;
`ifdef NAV_TIMEOUT_EN
                    seek_d  = SEEK_TIMEOUT;
`endif
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_RETURN_HOME: begin
                if (home_seen) begin
                    state_d = S_IDLE_BASE;
                end
`ifdef NAV_TIMEOUT_EN
                else if (seek_q <= 32'd1) begin
                    state_d = S_STOP;
                    fault_d = 1'b1;
                end else begin
                    seek_d = seek_q - 32'd1;
                end
`endif
            end
            S_STOP: begin
                // The clear count is compared as registered, so the resume
                // lands one cycle after the last required clear sample.
`ifdef NAV_TIMEOUT_EN
                if (fault_q) begin
                    state_d = S_STOP;
                end else
`endif
                if (obstacle) begin
                    clear_d = '0;
                end else if (clear_q >= CLEAR_CYCLES) begin
                    state_d = saved_q;
                    clear_d = '0;
                end else begin
                    clear_d = clear_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE_BASE;
                timer_d = '0;
                clear_d = '0;
            end
        endcase
    end

    // State, timer, clear counter, saved state and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE_BASE;
            saved_q <= S_IDLE_BASE;
            timer_q <= '0;
            clear_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            timer_q <= timer_d;
            clear_q <= clear_d;
            busy_q  <= (state_d != S_IDLE_BASE);
        end
    end

`ifdef NAV_TIMEOUT_EN
    // Seek watchdog counter and latched fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            seek_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            seek_q  <= seek_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign direction = state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_waiter_nav_sequencer.sv
// Self-checking bench for waiter_nav_sequencer: directed trip scenarios
// followed by random input traffic, compared every cycle with a leg-based
// behavioural model of the trip.
module tb_waiter_nav_sequencer;

    localparam int F = 4;
    localparam int T = 3;
    localparam int D = 5;
    localparam int C = 2;
    localparam int S = 10;

    logic       clk = 1'b0;
    logic       rst, start, obstacle, table_seen, home_seen, collect;
    logic [3:0] direction;
    logic       busy;
    logic       fault;

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    // Model: current leg code, cycles left in a timed leg, pause bookkeeping.
    int m_dir, m_left, m_saved, m_clear, m_seek;
    bit m_fault;

    waiter_nav_sequencer #(
        .FWD_CYCLES  (F),
        .TURN_CYCLES (T),
        .DWELL_CYCLES(D),
        .CLEAR_CYCLES(C),
        .SEEK_TIMEOUT(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .obstacle  (obstacle),
        .table_seen(table_seen),
        .home_seen (home_seen),
        .collect   (collect),
        .direction (direction),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    function automatic int leg_len(input int d);
        case (d)
            1, 5:    return F;
            2, 6:    return T;
            4:       return D;
            default: return 0;
        endcase
    endfunction

    task automatic seek_tick();
`ifdef NAV_TIMEOUT_EN
        m_seek--;
        if (m_seek == 0) begin
            m_fault = 1'b1;
            m_dir   = 8;
        end
`endif
    endtask

    task automatic model_update(input bit r, s, o, t, h, c);
        if (r) begin
            m_dir = 0; m_left = 0; m_saved = 0; m_clear = 0; m_seek = 0; m_fault = 1'b0;
        end else if (m_dir == 8) begin
            if (!m_fault) begin
                if (o) m_clear = 0;
                else if (m_clear >= C) begin
                    m_dir   = m_saved;
                    m_clear = 0;
                end else m_clear++;
            end
        end else if ((m_dir == 1 || m_dir == 3) && o) begin
            m_saved = m_dir;
            m_dir   = 8;
            m_clear = 0;
        end else begin
            case (m_dir)
                0: if (s) begin m_dir = 1; m_left = F; end
                1, 2, 5, 6: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_dir++;
                        m_left = leg_len(m_dir);
                        if (m_dir == 3 || m_dir == 7) m_seek = S;
                    end
                end
                3: if (t) begin m_dir = 4; m_left = D; end else seek_tick();
                4: begin
                    m_left--;
                    if (c || m_left == 0) begin m_dir = 5; m_left = F; end
                end
                7: if (h) m_dir = 0; else seek_tick();
                default: m_dir = 0;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        n_checks++;
        assert (obsv === expv)
        else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obsv, expv);
        end
    endtask

    // One clock: drive inputs, model the edge, sample 1 ns later.
    task automatic step(input bit r, s, o, t, h, c, input int exp_dir);
        rst = r; start = s; obstacle = o; table_seen = t; home_seen = h; collect = c;
        @(posedge clk);
        model_update(r, s, o, t, h, c);
        #1;
        chk("direction", {28'd0, direction}, m_dir);
        chk("busy", {31'd0, busy}, (m_dir != 0) ? 1 : 0);
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        if (exp_dir >= 0) chk("plan_direction", {28'd0, direction}, exp_dir);
    endtask

    task automatic idle(input int n, input int exp_dir);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, exp_dir);
    endtask

    task automatic obs(input int n, input int exp_dir);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 0, exp_dir);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; obstacle = 1'b0;
        table_seen = 1'b0; home_seen = 1'b0; collect = 1'b0;

        phase = "reset";
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_fault", {31'd0, fault}, 0);

        phase = "full_trip";
        step(0, 1, 0, 0, 0, 0, 1);
        idle(3, 1);
        idle(3, 2);
        idle(2, 3);
        step(0, 0, 0, 1, 0, 0, 4);
        idle(4, 4);
        idle(4, 5);
        idle(3, 6);
        idle(1, 7);
        step(0, 0, 0, 0, 1, 0, 0);

        phase = "obstacle_pause";
        step(0, 1, 0, 0, 0, 0, 1);
        idle(1, 1);
        obs(3, 8);
        idle(2, 8);
        idle(3, 1);
        idle(1, 2);

        phase = "turn_ignores_obstacle";
        obs(2, 2);
        obs(1, 3);

        phase = "obstacle_bounce";
        obs(1, 8);
        idle(1, 8);
        obs(1, 8);
        idle(2, 8);
        idle(1, 3);

        phase = "early_collect";
        step(0, 0, 0, 1, 0, 0, 4);
        step(0, 0, 1, 0, 0, 1, 5);
        obs(3, 5);
        obs(1, 6);
        idle(2, 6);
        idle(1, 7);
        step(0, 0, 0, 0, 1, 0, 0);

        phase = "obstacle_at_expiry";
        step(0, 1, 0, 0, 0, 0, 1);
        idle(3, 1);
        obs(1, 8);
        idle(2, 8);
        idle(1, 1);
        idle(1, 2);
        idle(2, 2);
        idle(1, 3);

        phase = "reset_in_stop";
        obs(1, 8);
        step(1, 0, 1, 0, 0, 0, 0);
        chk("reset_busy_mid", {31'd0, busy}, 0);
        step(0, 1, 0, 0, 0, 0, 1);
        idle(3, 1);
        idle(1, 2);
        idle(2, 2);
        idle(1, 3);

`ifdef NAV_TIMEOUT_EN
        phase = "seek_timeout";
        idle(9, 3);
        idle(1, 8);
        chk("fault_raised", {31'd0, fault}, 1);
        for (int i = 0; i < 6; i++) step(0, 0, (i % 2) == 0, 1, 1, 0, 8);
        chk("fault_held", {31'd0, fault}, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("fault_cleared", {31'd0, fault}, 0);
`else
        phase = "seek_wait";
        idle(20, 3);
        chk("no_fault", {31'd0, fault}, 0);
        step(0, 0, 0, 1, 0, 0, 4);
        step(0, 0, 0, 0, 0, 1, 5);
        idle(3, 5);
        idle(3, 6);
        idle(1, 7);
        step(0, 0, 0, 0, 1, 0, 0);
`endif

        phase = "random";
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0,
                 -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
